// File: rtl/evt_spike_serializer.sv
// Spike-vector capture FIFO that serializes each buffered vector into one event per firing neuron.
// Optional capture timestamps are enabled by defining SNE_SPIKE_TIMESTAMP_EN.
module evt_spike_serializer #(
   parameter int unsigned DP_GROUP   = 16,
   parameter int unsigned ENGINE_ID  = 0,
   parameter int unsigned NID_WIDTH  = 16,
   parameter int unsigned TIME_WIDTH = 32,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                  engine_clk_i,
   input  logic                  engine_rst_i,
   input  logic                  spike_valid_i,
   input  logic [DP_GROUP-1:0]   spike_i,
   input  logic [TIME_WIDTH-1:0] time_i,
   output logic                  evt_valid_o,
   input  logic                  evt_ready_i,
   output logic [NID_WIDTH-1:0]  evt_nid_o,
   output logic [TIME_WIDTH-1:0] evt_time_o,
   output logic                  busy_o,
   output logic                  overflow_o,
   input  logic                  overflow_clr_i,
   output logic [7:0]            drop_cnt_o
);

   localparam int unsigned PTR_W    = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned IDX_W    = (DP_GROUP > 1) ? $clog2(DP_GROUP) : 1;
   localparam int unsigned NID_BASE = ENGINE_ID * DP_GROUP;

   logic [DP_GROUP-1:0] vec_mem [FIFO_DEPTH];
   logic [PTR_W:0]      wr_ptr;
   logic [PTR_W:0]      rd_ptr;
   logic [PTR_W:0]      fill;
   logic [PTR_W-1:0]    wr_idx;
   logic [PTR_W-1:0]    rd_idx;
   logic [PTR_W-1:0]    rd_idx_nxt;
   logic [DP_GROUP-1:0] mask;
   logic [DP_GROUP-1:0] mask_next;
   logic [DP_GROUP-1:0] low_bit;
   logic [DP_GROUP-1:0] rest;
   logic [IDX_W-1:0]    low_idx;
   logic                empty;
   logic                full;
   logic                push_req;
   logic                push;
   logic                pop;
   logic                hs;
   logic                drop;
   logic                overflow;
   logic [7:0]          drop_cnt;

   // Pointer-derived occupancy; the extra MSB distinguishes full from empty.
   assign wr_idx     = wr_ptr[PTR_W-1:0];
   assign rd_idx     = rd_ptr[PTR_W-1:0];
   assign rd_idx_nxt = rd_idx + PTR_W'(1);
   assign fill       = wr_ptr - rd_ptr;
   assign empty      = (wr_ptr == rd_ptr);
   assign full       = (fill == (PTR_W+1)'(FIFO_DEPTH));

   assign push_req = spike_valid_i && (|spike_i);
   assign hs       = !empty && evt_ready_i;
   assign low_bit  = mask & (~mask + DP_GROUP'(1));
   assign rest     = mask & ~low_bit;
   assign pop      = hs && (rest == '0);
   assign push     = push_req && (!full || pop);
   assign drop     = push_req && full && !pop;

   // Lowest pending neuron index.
   always_comb begin
      logic found;
      low_idx = '0;
      found   = 1'b0;
      for (int i = 0; i < int'(DP_GROUP); i++) begin
         if (mask[i] && !found) begin
            low_idx = IDX_W'(i);
            found   = 1'b1;
         end
      end
   end

   // Head mask: reload on head change, otherwise retire the served bit.
   always_comb begin
      mask_next = mask;
      if (empty) begin
         if (push) mask_next = spike_i;
      end else if (pop) begin
         if (fill != (PTR_W+1)'(1)) mask_next = vec_mem[rd_idx_nxt];
         else if (push)             mask_next = spike_i;
         else                       mask_next = '0;
      end else if (hs) begin
         mask_next = rest;
      end
   end

   always_ff @(posedge engine_clk_i) begin
      if (push) vec_mem[wr_idx] <= spike_i;
   end

   always_ff @(posedge engine_clk_i) begin
      if (engine_rst_i) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         mask     <= '0;
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
         mask <= mask_next;
         // A drop coinciding with a clear restarts the count at one.
         if (drop) begin
            overflow <= 1'b1;
            if (overflow_clr_i)          drop_cnt <= 8'd1;
            else if (drop_cnt != 8'hFF)  drop_cnt <= drop_cnt + 8'd1;
         end else if (overflow_clr_i) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
         end
      end
   end

   assign evt_valid_o = !empty;
   assign busy_o      = !empty;
   assign overflow_o  = overflow;
   assign drop_cnt_o  = drop_cnt;
   assign evt_nid_o   = empty ? '0 : NID_WIDTH'(NID_BASE) + NID_WIDTH'(low_idx);

`ifdef SNE_SPIKE_TIMESTAMP_EN
   logic [TIME_WIDTH-1:0] time_mem [FIFO_DEPTH];

   always_ff @(posedge engine_clk_i) begin
      if (push) time_mem[wr_idx] <= time_i;
   end

   assign evt_time_o = empty ? '0 : time_mem[rd_idx];
`else
   logic unused_time;

   assign unused_time = ^time_i;
   assign evt_time_o  = '0;
`endif

endmodule

// File: tb/tb_evt_spike_serializer.sv
// Directed bench for evt_spike_serializer with an event scoreboard and stability monitor.
module tb_evt_spike_serializer;

   typedef struct packed {
      logic [15:0] nid;
      logic [31:0] t;
   } ev_t;

   logic        clk;
   logic        rst;
   logic        spike_valid;
   logic [15:0] spike;
   logic [31:0] tm;
   logic        evt_valid;
   logic        evt_ready;
   logic [15:0] evt_nid;
   logic [31:0] evt_time;
   logic        busy;
   logic        overflow;
   logic        overflow_clr;
   logic [7:0]  drop_cnt;

   int   checks = 0;
   int   errors = 0;
   ev_t  exp_q[$];
   bit   hold = 0;
   logic [15:0] h_nid;
   logic [31:0] h_time;

   evt_spike_serializer #(
      .DP_GROUP(16), .ENGINE_ID(2), .NID_WIDTH(16), .TIME_WIDTH(32), .FIFO_DEPTH(4)
   ) dut (
      .engine_clk_i  (clk),
      .engine_rst_i  (rst),
      .spike_valid_i (spike_valid),
      .spike_i       (spike),
      .time_i        (tm),
      .evt_valid_o   (evt_valid),
      .evt_ready_i   (evt_ready),
      .evt_nid_o     (evt_nid),
      .evt_time_o    (evt_time),
      .busy_o        (busy),
      .overflow_o    (overflow),
      .overflow_clr_i(overflow_clr),
      .drop_cnt_o    (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_time(input logic [31:0] t);
`ifdef SNE_SPIKE_TIMESTAMP_EN
      return t;
`else
      return (t & 32'h0);
`endif
   endfunction

   task automatic push_vec(input logic [15:0] v, input logic [31:0] t, input bit accept);
      ev_t e;
      spike_valid = 1'b1;
      spike       = v;
      tm          = t;
      if (accept) begin
         for (int i = 0; i < 16; i++) begin
            if (v[i]) begin
               e.nid = 16'(32 + i);
               e.t   = exp_time(t);
               exp_q.push_back(e);
            end
         end
      end
      @(posedge clk); #1;
      spike_valid = 1'b0;
      spike       = '0;
   endtask

   task automatic drain(input string tag);
      evt_ready = 1'b1;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !busy) break;
      end
      check({tag, "_queue_left"}, 64'(exp_q.size()), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
   endtask

   // Scoreboard and hold-stability monitor on the falling edge.
   always @(negedge clk) begin
      ev_t e;
      if (rst) begin
         hold = 0;
      end else begin
         if (hold) begin
            check("stable_valid", 64'(evt_valid), 64'd1);
            check("stable_nid", 64'(evt_nid), 64'(h_nid));
            check("stable_time", 64'(evt_time), 64'(h_time));
         end
         if (evt_valid && evt_ready) begin
            check("evt_expected_present", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("evt_nid", 64'(evt_nid), 64'(e.nid));
               check("evt_time", 64'(evt_time), 64'(e.t));
            end
         end
         hold   = evt_valid && !evt_ready;
         h_nid  = evt_nid;
         h_time = evt_time;
      end
   end

   initial begin
      rst = 1'b1; spike_valid = 1'b0; spike = '0; tm = '0;
      evt_ready = 1'b0; overflow_clr = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_valid", 64'(evt_valid), 64'd0);
      check("rst_nid", 64'(evt_nid), 64'd0);
      check("rst_time", 64'(evt_time), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_overflow", 64'(overflow), 64'd0);
      check("rst_drop_cnt", 64'(drop_cnt), 64'd0);

      // Single vector, ready high: 32, 34, 47 on consecutive cycles.
      @(posedge clk); #1;
      evt_ready = 1'b1;
      push_vec(16'h8005, 32'd100, 1'b1);
      @(negedge clk);
      check("single_latency_valid", 64'(evt_valid), 64'd1);
      check("single_first_nid", 64'(evt_nid), 64'd32);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("single_three_cycles_busy", 64'(busy), 64'd0);
      check("single_three_cycles_queue", 64'(exp_q.size()), 64'd0);

      // Back-pressure holds nid 32 until ready rises.
      evt_ready = 1'b0;
      push_vec(16'h8005, 32'd200, 1'b1);
      repeat (5) begin
         @(negedge clk);
         check("bp_valid", 64'(evt_valid), 64'd1);
         check("bp_nid", 64'(evt_nid), 64'd32);
      end
      drain("bp");

      // Overflow: fifth vector dropped while ready is low.
      @(posedge clk); #1;
      evt_ready = 1'b0;
      push_vec(16'h0001, 32'd1, 1'b1);
      push_vec(16'h0002, 32'd2, 1'b1);
      push_vec(16'h0004, 32'd3, 1'b1);
      push_vec(16'h0008, 32'd4, 1'b1);
      push_vec(16'h0010, 32'd5, 1'b0);
      @(negedge clk);
      check("ovf_flag", 64'(overflow), 64'd1);
      check("ovf_drop_cnt", 64'(drop_cnt), 64'd1);
      drain("ovf");
      check("ovf_sticky", 64'(overflow), 64'd1);
      @(posedge clk); #1;
      overflow_clr = 1'b1;
      @(posedge clk); #1;
      overflow_clr = 1'b0;
      @(negedge clk);
      check("clr_flag", 64'(overflow), 64'd0);
      check("clr_drop_cnt", 64'(drop_cnt), 64'd0);

      // Push into full FIFO accepted alongside a pop of the head's last bit.
      @(posedge clk); #1;
      evt_ready = 1'b0;
      push_vec(16'h0003, 32'd10, 1'b1);
      push_vec(16'h0004, 32'd11, 1'b1);
      push_vec(16'h0008, 32'd12, 1'b1);
      push_vec(16'h0010, 32'd13, 1'b1);
      evt_ready = 1'b1;
      @(posedge clk); #1;
      push_vec(16'h0001, 32'd14, 1'b1);
      @(negedge clk);
      check("full_pop_overflow", 64'(overflow), 64'd0);
      check("full_pop_drop_cnt", 64'(drop_cnt), 64'd0);
      drain("full_pop");

      // Zero vector is ignored.
      @(posedge clk); #1;
      spike_valid = 1'b1; spike = 16'h0000; tm = 32'd77;
      @(posedge clk); #1;
      spike_valid = 1'b0;
      @(negedge clk);
      check("zero_valid", 64'(evt_valid), 64'd0);
      check("zero_busy", 64'(busy), 64'd0);
      check("zero_drop_cnt", 64'(drop_cnt), 64'd0);
      check("zero_overflow", 64'(overflow), 64'd0);

      // Drop counter saturation.
      @(posedge clk); #1;
      evt_ready = 1'b0;
      push_vec(16'h0001, 32'd20, 1'b1);
      push_vec(16'h0002, 32'd21, 1'b1);
      push_vec(16'h0004, 32'd22, 1'b1);
      push_vec(16'h0008, 32'd23, 1'b1);
      for (int k = 0; k < 300; k++) push_vec(16'h0100, 32'(100 + k), 1'b0);
      @(negedge clk);
      check("sat_drop_cnt", 64'(drop_cnt), 64'd255);
      check("sat_overflow", 64'(overflow), 64'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("sat_rst_drop_cnt", 64'(drop_cnt), 64'd0);
      check("sat_rst_overflow", 64'(overflow), 64'd0);
      check("sat_rst_busy", 64'(busy), 64'd0);

      // Mid-operation reset while nid 34 is pending.
      @(posedge clk); #1;
      evt_ready = 1'b1;
      push_vec(16'h8005, 32'd300, 1'b1);
      @(posedge clk); #1;
      check("mid_pending_nid", 64'(evt_nid), 64'd34);
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_valid", 64'(evt_valid), 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_nid", 64'(evt_nid), 64'd0);
      @(posedge clk); #1;
      push_vec(16'h0002, 32'd400, 1'b1);
      @(negedge clk);
      check("post_rst_nid", 64'(evt_nid), 64'd33);
      drain("post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      errors++;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
